// File: rtl/circuit_sweep_pkg.sv
// Shared types and sizing helpers for the circuit sweep sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package circuit_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Truth-table width for an n-input circuit.
   function automatic int tt_width(input int nvars);
      return 1 << nvars;
   endfunction

   // Counter width able to hold 0..max_val, never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/circuit_sweep_ctrl_lowest_diff_idx.sv
// Priority encoder returning the lowest set bit index of a difference vector.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
// Ports: diff (TT_W) in, idx (NVARS) out = lowest set bit or 0, any_diff out = |diff.
module lowest_diff_idx
   import circuit_sweep_pkg::*;
#(
   parameter  int NVARS = 3,
   localparam int TT_W  = tt_width(NVARS)
) (
   input  logic [TT_W-1:0]  diff,
   output logic [NVARS-1:0] idx,
   output logic             any_diff
);

   // Scan from the top down so the last hit written is the lowest index.
   always_comb begin
      idx = '0;
      for (int i = TT_W - 1; i >= 0; i--) begin
         if (diff[i]) idx = NVARS'(i);
      end
   end

   assign any_diff = |diff;

endmodule

// File: rtl/circuit_sweep_ctrl.sv
// Sweeps a combinational circuit through every input vector and builds its truth table.
// Latency: 2**NVARS * (SETTLE_CYCLES+1) cycles from start accept to the done pulse.
// Backpressure: start is ignored while busy (no queuing); abort cancels a sweep, no done.
// Ports: clk, rst_n, start, abort, expected (TT_W), f_in  ->  vec_out (NVARS), busy, done,
//        truth_table (TT_W), match, mismatch_idx (NVARS). All outputs registered.
module circuit_sweep_ctrl
   import circuit_sweep_pkg::*;
#(
   parameter  int NVARS         = 3,
   parameter  int SETTLE_CYCLES = 2,
   localparam int TT_W          = tt_width(NVARS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [TT_W-1:0]  expected,
   input  logic             f_in,
   output logic [NVARS-1:0] vec_out,
   output logic             busy,
   output logic             done,
   output logic [TT_W-1:0]  truth_table,
   output logic             match,
   output logic [NVARS-1:0] mismatch_idx
);

   localparam int               CW          = cnt_width(SETTLE_CYCLES);
   localparam logic [CW-1:0]    SETTLE_LAST = CW'(SETTLE_CYCLES);
   localparam logic [NVARS-1:0] VEC_LAST    = NVARS'(TT_W - 1);

   state_t            state, state_nxt;
   logic [CW-1:0]     settle_cnt;
   logic [TT_W-1:0]   expected_q;
   logic [TT_W-1:0]   tt_nxt;
   logic              accept;
   logic              sample_now;
   logic              last_sample;
   logic              any_diff;
   logic [NVARS-1:0]  diff_idx;

   // A start is taken only outside RUN, and abort vetoes it in the same cycle.
   assign accept      = start & ~abort & (state != RUN);
   assign sample_now  = (state == RUN) & ~abort & (settle_cnt == SETTLE_LAST);
   assign last_sample = sample_now & (vec_out == VEC_LAST);

   // Table as it will look after this cycle's sample, so the final compare sees the last bit.
   always_comb begin
      tt_nxt          = truth_table;
      tt_nxt[vec_out] = f_in;
   end

   lowest_diff_idx #(.NVARS(NVARS)) u_lowest_diff_idx (
      .diff     (tt_nxt ^ expected_q),
      .idx      (diff_idx),
      .any_diff (any_diff)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (accept) state_nxt = RUN;
         RUN: begin
            if (abort)            state_nxt = IDLE;
            else if (last_sample) state_nxt = DONE;
         end
         DONE:    state_nxt = accept ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vec_out      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         truth_table  <= '0;
         match        <= 1'b0;
         mismatch_idx <= '0;
         settle_cnt   <= '0;
         expected_q   <= '0;
      end else begin
         done <= last_sample;
         if (accept) begin
            busy        <= 1'b1;
            vec_out     <= '0;
            settle_cnt  <= '0;
            truth_table <= '0;
            expected_q  <= expected;
            match       <= 1'b0;
         end else if (state == RUN) begin
            if (abort) begin
               // Keep the bits already sampled; drop the verdict.
               busy         <= 1'b0;
               vec_out      <= '0;
               settle_cnt   <= '0;
               match        <= 1'b0;
               mismatch_idx <= '0;
            end else if (sample_now) begin
               truth_table <= tt_nxt;
               settle_cnt  <= '0;
               vec_out     <= vec_out + 1'b1;   // wraps to 0 after the last vector
               if (last_sample) begin
                  busy         <= 1'b0;
                  match        <= ~any_diff;
                  mismatch_idx <= diff_idx;
               end
            end else begin
               settle_cnt <= settle_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Bench for circuit_sweep_ctrl: two instances (SETTLE_CYCLES=2 and 0) driving the lab F1 load,
// checked every cycle against a sweep-level model plus directed literal expectations.
// Latency/backpressure: n/a.
module tb_circuit_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [7:0] expected = 8'h00;

   always #5 clk = ~clk;

   logic [2:0] vec0, vec1, idx0, idx1;
   logic       busy0, busy1, done0, done1, match0, match1, f0, f1;
   logic [7:0] tt0, tt1;

   // Lab F1 circuit under test; A is vec[2], C is vec[0].
   function automatic logic lab_f1(input logic [2:0] v);
      logic [7:0] t;
      t = 8'hDA;
      return t[v];
   endfunction

   assign f0 = lab_f1(vec0);
   assign f1 = lab_f1(vec1);

   circuit_sweep_ctrl #(.NVARS(3), .SETTLE_CYCLES(2)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
      .f_in(f0), .vec_out(vec0), .busy(busy0), .done(done0), .truth_table(tt0),
      .match(match0), .mismatch_idx(idx0));

   circuit_sweep_ctrl #(.NVARS(3), .SETTLE_CYCLES(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
      .f_in(f1), .vec_out(vec1), .busy(busy1), .done(done1), .truth_table(tt1),
      .match(match1), .mismatch_idx(idx1));

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int inst, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[u%0d] got %0h want %0h (cyc %0d)", name, inst, act, exp, cyc);
   endtask

   // ---------------- behavioural model ----------------
   // A sweep is a timeline measured from the accept edge: vector k lives in
   // [k*P, (k+1)*P), F(k) is captured at (k+1)*P, and the sweep ends at 8*P.
   bit         m_run  [2];
   int         m_t    [2];
   logic       m_busy [2], m_done [2], m_match [2];
   logic [2:0] m_vec  [2], m_idx [2];
   logic [7:0] m_tt   [2], m_expq [2];
   int         mper, mk;

   function automatic int settle_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic logic [2:0] lowest_bit(input logic [7:0] d);
      for (int k = 0; k < 8; k++) if (d[k]) return 3'(k);
      return 3'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_run[i] = 0; m_t[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_match[i] = 0;
            m_vec[i] = 0; m_idx[i] = 0; m_tt[i] = 0; m_expq[i] = 0;
         end else if (m_run[i]) begin
            mper = settle_of(i) + 1;
            if (abort) begin
               m_run[i] = 0; m_busy[i] = 0; m_vec[i] = 0; m_match[i] = 0; m_idx[i] = 0;
            end else begin
               m_t[i]++;
               if (m_t[i] % mper == 0) begin
                  mk = m_t[i] / mper - 1;
                  m_tt[i][mk] = lab_f1(3'(mk));
                  if (m_t[i] == 8 * mper) begin
                     m_run[i] = 0; m_busy[i] = 0; m_done[i] = 1; m_vec[i] = 0;
                     m_match[i] = (m_tt[i] == m_expq[i]);
                     m_idx[i]   = lowest_bit(m_tt[i] ^ m_expq[i]);
                  end else begin
                     m_vec[i] = 3'(m_t[i] / mper);
                  end
               end
            end
         end else begin
            m_done[i] = 0;
            if (start && !abort) begin
               m_run[i] = 1; m_t[i] = 0; m_busy[i] = 1; m_vec[i] = 0;
               m_tt[i] = 0; m_expq[i] = expected; m_match[i] = 0;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("vec_out", 0, vec0, m_vec[0]);   chk("vec_out", 1, vec1, m_vec[1]);
         chk("busy", 0, busy0, m_busy[0]);    chk("busy", 1, busy1, m_busy[1]);
         chk("done", 0, done0, m_done[0]);    chk("done", 1, done1, m_done[1]);
         chk("truth_table", 0, tt0, m_tt[0]); chk("truth_table", 1, tt1, m_tt[1]);
         chk("match", 0, match0, m_match[0]); chk("match", 1, match1, m_match[1]);
         chk("mismatch_idx", 0, idx0, m_idx[0]); chk("mismatch_idx", 1, idx1, m_idx[1]);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic pulse_start(input logic [7:0] e, output int e0);
      @(negedge clk);
      expected = e;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e0    = cyc;   // cyc now equals the index of the accept edge
   endtask

   task automatic wait_done0(input int budget);
      bit ok;
      ok = 0;
      for (int n = 0; n < budget; n++) begin
         @(negedge clk);
         if (done0) begin
            ok = 1;
            break;
         end
      end
      chk("done_within_budget", 0, 8'(ok), 8'd1);
   endtask

   int  e0, cnt;
   bit  seen;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 0, busy0, 0);  chk("rst_done", 0, done0, 0);
      chk("rst_vec", 0, vec0, 0);    chk("rst_tt", 0, tt0, 0);
      chk("rst_match", 0, match0, 0); chk("rst_idx", 0, idx0, 0);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      repeat (3) @(negedge clk);

      // 1: matching sweep, busy for 24 cycles, done at E0+24
      pulse_start(8'hDA, e0);
      cnt = 0;
      while (busy0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("t1_busy_len", 0, 8'(cnt), 8'd24);
      chk("t1_done_at", 0, 8'(cyc - e0), 8'd24);
      chk("t1_done", 0, done0, 1);
      chk("t1_tt", 0, tt0, 8'hDA);
      chk("t1_match", 0, match0, 1);
      chk("t1_idx", 0, idx0, 0);
      repeat (5) @(negedge clk);
      chk("t1_done_low", 0, done0, 0);

      // 2: mismatching expectations
      pulse_start(8'hDB, e0);
      wait_done0(40);
      chk("t2a_tt", 0, tt0, 8'hDA);
      chk("t2a_match", 0, match0, 0);
      chk("t2a_idx", 0, idx0, 3'd0);
      repeat (3) @(negedge clk);
      pulse_start(8'h5A, e0);
      wait_done0(40);
      chk("t2b_match", 0, match0, 0);
      chk("t2b_idx", 0, idx0, 3'd7);
      repeat (3) @(negedge clk);

      // 3: abort sampled at edge E0+10
      pulse_start(8'hDA, e0);
      while (cyc < e0 + 9) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t3_at", 0, 8'(cyc - e0), 8'd10);
      chk("t3_busy", 0, busy0, 0);
      chk("t3_vec", 0, vec0, 0);
      chk("t3_tt", 0, tt0, 8'h02);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done0) seen = 1;
      end
      chk("t3_no_done", 0, 8'(seen), 8'd0);

      // 4: start held high -> back-to-back sweeps
      @(negedge clk);
      expected = 8'hDA;
      start    = 1'b1;
      wait_done0(60);
      chk("t4_busy_in_done", 0, busy0, 0);
      @(negedge clk);
      chk("t4_busy_restart", 0, busy0, 1);
      chk("t4_done_cleared", 0, done0, 0);
      cnt = 0;
      while (busy0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("t4_busy_len", 0, 8'(cnt), 8'd24);
      chk("t4_done2", 0, done0, 1);
      start = 1'b0;
      @(negedge clk);
      chk("t4_idle", 0, busy0, 0);
      repeat (30) @(negedge clk);

      // 5: SETTLE_CYCLES=0 instance steps every cycle
      pulse_start(8'hDA, e0);
      for (int k = 0; k < 8; k++) begin
         chk("t5_vec_step", 1, vec1, 8'(k));
         @(negedge clk);
      end
      chk("t5_done_at", 1, 8'(cyc - e0), 8'd8);
      chk("t5_done", 1, done1, 1);
      chk("t5_tt", 1, tt1, 8'hDA);
      repeat (30) @(negedge clk);

      // 6: asynchronous reset mid-sweep
      pulse_start(8'hDA, e0);
      while (cyc < e0 + 12) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", 0, busy0, 0);  chk("t6_vec", 0, vec0, 0);
      chk("t6_tt", 0, tt0, 0);      chk("t6_match", 0, match0, 0);
      chk("t6_done", 0, done0, 0);  chk("t6_idx", 0, idx0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      pulse_start(8'hDA, e0);
      wait_done0(40);
      chk("t6_tt_after", 0, tt0, 8'hDA);
      chk("t6_match_after", 0, match0, 1);
      repeat (5) @(negedge clk);

      // Random traffic, checked by the per-cycle model compare
      repeat (3000) begin
         @(negedge clk);
         start    = ($urandom_range(0, 9) == 0);
         abort    = ($urandom_range(0, 59) == 0);
         expected = ($urandom_range(0, 1) == 1) ? 8'hDA : 8'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      repeat (40) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
